serial_tx2: RTL and testbench

SERIAL_TX2 -- requirements
Module: serial_tx2

---
 rtl/serial_tx2.sv | 148 ++++++++++++++
 tb/tb_serial_tx2.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx2.sv
// serial_tx2: 8N1 serial transmitter with registered flow control.
// Define SERIAL_TX_PARITY_EN to add an even-parity bit before the stop bit.
`timescale 1ns/1ps

module serial_tx2 #(
    parameter int CLK_PER_BIT = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       block,
    input  logic [7:0] data,
    input  logic       new_data,
    output logic       busy,
    output logic       tx
);

    localparam int CW =
        (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CW-1:0] CYC_LAST =
        CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] CYC_ONE = CW'(1);

    typedef enum logic [2:0] {
`ifdef SERIAL_TX_PARITY_EN
        PARITY    = 3'd4,
`endif
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA      = 3'd2,
        STOP_BIT  = 3'd3
    } state_t;

    state_t          state_q, state_d;
    logic            tx_q, tx_d;
    logic            block_q;
    logic [2:0]      bit_q, bit_d;
    logic [2:0]      bit_nxt;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [7:0]      data_q, data_d;
    logic            bit_end;
    logic            accept;

    assign busy    = (state_q != IDLE) | block_q;
    assign tx      = tx_q;
    assign bit_end = (cyc_q == CYC_LAST);
    assign accept  = (state_q == IDLE) & ~block_q & new_data;
    assign bit_nxt = bit_q + 3'd1;

    // Next state, next line level and counters; tx_d is the level of
    // the cycle after the edge so the line comes straight from a flop.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        bit_d   = bit_q;
        cyc_d   = cyc_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                tx_d  = 1'b1;
                cyc_d = '0;
                bit_d = '0;
                if (accept) begin
                    data_d  = data;
                    state_d = START_BIT;
                    tx_d    = 1'b0;
                end
            end
            START_BIT: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = data_q[0];
                    cyc_d   = '0;
                    bit_d   = '0;
                end else begin
                    cyc_d = cyc_q + CYC_ONE;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cyc_d = '0;
                    bit_d = bit_nxt;
                    if (bit_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = ^data_q;
`else
                        state_d = STOP_BIT;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        tx_d = data_q[bit_nxt];
                    end
                end else begin
                    cyc_d = cyc_q + CYC_ONE;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP_BIT;
                    tx_d    = 1'b1;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CYC_ONE;
                end
            end
`endif
            STOP_BIT: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    state_d = IDLE;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CYC_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                cyc_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Control state with synchronous reset; reset leaves the line idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            bit_q   <= '0;
            cyc_q   <= '0;
            block_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            bit_q   <= bit_d;
            cyc_q   <= cyc_d;
            block_q <= block;
        end
    end

    // Latched frame byte; only read after an accept loads it.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

endmodule

// File: tb/tb_serial_tx2.sv
// tb_serial_tx2: random and directed stimulus against a frame-level
// model; a receiver process decodes tx and checks a scoreboard queue.
`timescale 1ns/1ps

module tb_serial_tx2;

    localparam int N = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * N;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       block = 1'b0;
    logic       new_data = 1'b0;
    logic [7:0] data = 8'h00;
    logic       busy;
    logic       tx;

    serial_tx2 #(.CLK_PER_BIT(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .block    (block),
        .data     (data),
        .new_data (new_data),
        .busy     (busy),
        .tx       (tx)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         rem_m = 0;
    bit         blk_m = 1'b0;
    bit         chk_en = 1'b0;
    int         frames = 0;
    logic [7:0] exp_q[$];
    int         starts[$];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Frame-level model: a request is taken when no frame is pending
    // and the registered block is low; a frame then owns FRAME cycles.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            rem_m = 0;
            blk_m = 1'b0;
            exp_q.delete();
        end else begin
            if (rem_m == 0 && !blk_m && new_data) begin
                rem_m = FRAME;
                exp_q.push_back(data);
            end else if (rem_m > 0) begin
                rem_m--;
            end
            blk_m = block;
        end
    end

    // Per-cycle busy and idle-line checks.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, (rem_m > 0) || blk_m);
            if (rem_m == 0) chk("idle_tx", tx, 1);
        end
    end

    // Reference receiver: decodes each frame and pops the scoreboard.
    initial begin : rx
        logic       smp [FRAME];
        bit         ab;
        bit         ok;
        logic [7:0] b;
        logic [7:0] e;
        int         st;
        forever begin
            @(negedge clk);
            if (chk_en && !rst && tx === 1'b0) begin
                st = cyc;
                ab = 1'b0;
                smp[0] = tx;
                for (int i = 1; i < FRAME; i++) begin
                    @(negedge clk);
                    if (rst) begin
                        ab = 1'b1;
                        break;
                    end
                    smp[i] = tx;
                end
                if (!ab) begin
                    ok = 1'b1;
                    for (int k = 0; k < FRAME; k++)
                        if (smp[k] !== smp[(k / N) * N]) ok = 1'b0;
                    if (smp[0] !== 1'b0) ok = 1'b0;
                    if (smp[FRAME-1] !== 1'b1) ok = 1'b0;
                    chk("frame_shape", ok, 1);
                    for (int k = 0; k < 8; k++)
                        b[k] = smp[(k + 1) * N];
                    frames++;
                    starts.push_back(st);
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_frame: got %0h expected none",
                                 b);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_byte", b, e);
`ifdef SERIAL_TX_PARITY_EN
                        chk("parity_bit", smp[9 * N], ^e);
`endif
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        data = 8'($urandom);
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        while ((rem_m != 0 || blk_m) && n < 5000) begin
            tick();
            n++;
        end
        if (n >= 5000) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got busy expected idle");
        end
        new_data = 1'b1;
        data = b;
        tick();
        new_data = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (rem_m != 0 && n < 5000) begin
            tick();
            n++;
        end
        if (n >= 5000) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: got busy expected idle");
        end
        repeat (3) tick();
    endtask

    initial begin : wdog
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n0;
        int f0;
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_busy", busy, 0);
        chk("reset_tx", tx, 1);

        f0 = frames;
        send(8'hA5);
        chk("busy_after_accept", busy, 1);
        chk("start_tx", tx, 0);
        repeat (12) tick();
        new_data = 1'b1;
        data = 8'h33;
        tick();
        new_data = 1'b0;
        wait_idle();
        chk("ignored_frames", frames - f0, 1);

        n0 = starts.size();
        send(8'h00);
        send(8'hFF);
        wait_idle();
        chk("b2b_frames", starts.size() - n0, 2);
        if (starts.size() - n0 == 2)
            chk("b2b_gap", starts[n0+1] - starts[n0], FRAME + 1);

        block = 1'b1;
        repeat (3) tick();
        new_data = 1'b1;
        tick();
        new_data = 1'b0;
        chk("blocked_busy", busy, 1);
        chk("blocked_tx", tx, 1);
        repeat (4) tick();
        block = 1'b0;
        chk("block_lag_busy", busy, 1);
        tick();
        chk("unblock_busy", busy, 0);
        send(8'hC3);
        wait_idle();

        send(8'h96);
        repeat (4 * N + 1) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        f0 = frames;
        send(8'h5A);
        wait_idle();
        chk("post_rst_frames", frames - f0, 1);

`ifdef SERIAL_TX_PARITY_EN
        send(8'h07);
        send(8'h03);
        wait_idle();
`endif

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) block = ~block;
            new_data = ($urandom_range(0, 4) == 0);
            tick();
        end
        block = 1'b0;
        new_data = 1'b0;
        wait_idle();
        chk("queue_drained", exp_q.size(), 0);
        chk("frames_min", frames >= 12, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
